// File: rtl/palette_rgb_out_if.sv
// Pixel/sync stream from the scanner, CPU palette write port and RGB/sync outputs
// bundled for the palette output stage.
interface palette_rgb_out_if;
    logic       ce12;
    logic       hsync;
    logic       vsync;
    logic       videoActive;
    logic       border;
    logic [3:0] coloridx;
    logic [3:0] border_idx;
    logic       pal_wr;
    logic [7:0] pal_data;
    logic       pal_busy;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;
    logic       vga_hs;
    logic       vga_vs;

    modport master (
        output ce12, hsync, vsync, videoActive, border, coloridx,
               border_idx, pal_wr, pal_data,
        input  pal_busy, vga_r, vga_g, vga_b, vga_hs, vga_vs
    );

    modport slave (
        input  ce12, hsync, vsync, videoActive, border, coloridx,
               border_idx, pal_wr, pal_data,
        output pal_busy, vga_r, vga_g, vga_b, vga_hs, vga_vs
    );
endinterface

// File: rtl/palette_rgb_out.sv
// Palette lookup and RGB expansion behind the video scanner, with a two-stage
// pipeline and CPU palette writes deferred to the next ce12 strobe.
module palette_rgb_out #(
    parameter bit BLANK_BORDER = 1'b0
) (
    input  logic               clk24,
    input  logic               reset,
    palette_rgb_out_if.slave   bus
);

    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} wrState_t;

    wrState_t   r_state;
    logic       r_busy;
    logic [3:0] r_addr;
    logic [7:0] r_data;
    logic [7:0] r_pal [16];

    logic [3:0] r_selIdx;
    logic       r_blank;
    logic       r_hs1;
    logic       r_vs1;

    logic [3:0] r_vgaR;
    logic [3:0] r_vgaG;
    logic [3:0] r_vgaB;
    logic       r_vgaHs;
    logic       r_vgaVs;

    logic [7:0] w_entry;

    // Commit only on ce12 so an entry never changes between the two halves of a mode512 pixel.
    always_ff @(posedge clk24) begin
        if (reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_addr  <= 4'h0;
            r_data  <= 8'h00;
            for (int i = 0; i < 16; i++) begin
                r_pal[i] <= 8'h00;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.pal_wr) begin
                        r_addr  <= bus.border_idx;
                        r_data  <= bus.pal_data;
                        r_state <= PEND;
                        r_busy  <= 1'b1;
                    end
                end
                PEND: begin
                    if (bus.ce12) begin
                        r_pal[r_addr] <= r_data;
                    end
                    if (bus.pal_wr) begin
                        r_addr  <= bus.border_idx;
                        r_data  <= bus.pal_data;
                        r_state <= PEND;
                        r_busy  <= 1'b1;
                    end else if (bus.ce12) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk24) begin
        if (reset) begin
            r_selIdx <= 4'h0;
            r_blank  <= 1'b1;
            r_hs1    <= 1'b1;
            r_vs1    <= 1'b1;
        end else begin
            r_selIdx <= bus.border ? bus.border_idx : bus.coloridx;
            r_blank  <= !bus.videoActive | (bus.border & BLANK_BORDER);
            r_hs1    <= bus.hsync;
            r_vs1    <= bus.vsync;
        end
    end

    // Read sees the pre-commit entry on the commit edge; there is deliberately no bypass.
    assign w_entry = r_pal[r_selIdx];

    always_ff @(posedge clk24) begin
        if (reset) begin
            r_vgaR  <= 4'h0;
            r_vgaG  <= 4'h0;
            r_vgaB  <= 4'h0;
            r_vgaHs <= 1'b1;
            r_vgaVs <= 1'b1;
        end else begin
            r_vgaR  <= r_blank ? 4'h0 : {w_entry[2:0], w_entry[2]};
            r_vgaG  <= r_blank ? 4'h0 : {w_entry[5:3], w_entry[5]};
            r_vgaB  <= r_blank ? 4'h0 : {w_entry[7:6], w_entry[7:6]};
            r_vgaHs <= r_hs1;
            r_vgaVs <= r_vs1;
        end
    end

    assign bus.pal_busy = r_busy;
    assign bus.vga_r    = r_vgaR;
    assign bus.vga_g    = r_vgaG;
    assign bus.vga_b    = r_vgaB;
    assign bus.vga_hs   = r_vgaHs;
    assign bus.vga_vs   = r_vgaVs;

endmodule

// File: tb/tb_palette_rgb_out.sv
// Directed bench for palette_rgb_out: one instance with border shown through the
// palette, one with border blanked, both fed the same stimulus.
module tb_palette_rgb_out;

    logic       clk24;
    logic       reset;
    logic       ce12;
    logic       hsync;
    logic       vsync;
    logic       videoActive;
    logic       border;
    logic [3:0] coloridx;
    logic [3:0] border_idx;
    logic       pal_wr;
    logic [7:0] pal_data;

    int compared   = 0;
    int mismatched = 0;

    palette_rgb_out_if busA ();
    palette_rgb_out_if busB ();

    assign busA.ce12        = ce12;
    assign busA.hsync       = hsync;
    assign busA.vsync       = vsync;
    assign busA.videoActive = videoActive;
    assign busA.border      = border;
    assign busA.coloridx    = coloridx;
    assign busA.border_idx  = border_idx;
    assign busA.pal_wr      = pal_wr;
    assign busA.pal_data    = pal_data;

    assign busB.ce12        = ce12;
    assign busB.hsync       = hsync;
    assign busB.vsync       = vsync;
    assign busB.videoActive = videoActive;
    assign busB.border      = border;
    assign busB.coloridx    = coloridx;
    assign busB.border_idx  = border_idx;
    assign busB.pal_wr      = pal_wr;
    assign busB.pal_data    = pal_data;

    palette_rgb_out #(.BLANK_BORDER(1'b0)) dutA (
        .clk24 (clk24),
        .reset (reset),
        .bus   (busA.slave)
    );

    palette_rgb_out #(.BLANK_BORDER(1'b1)) dutB (
        .clk24 (clk24),
        .reset (reset),
        .bus   (busB.slave)
    );

    logic [11:0] rgbA;
    logic [11:0] rgbB;
    assign rgbA = {busA.vga_r, busA.vga_g, busA.vga_b};
    assign rgbB = {busB.vga_r, busB.vga_g, busB.vga_b};

    initial clk24 = 1'b0;
    always #5 clk24 = ~clk24;

    // ce12 toggles right after every edge, so its value always describes the next edge.
    task automatic tick();
        @(posedge clk24);
        #1;
        ce12 = ~ce12;
    endtask

    task automatic alignCe(input logic want);
        if (ce12 !== want) tick();
    endtask

    task automatic applyStimulus(input logic va, input logic bord,
                                 input logic [3:0] cidx, input logic [3:0] bidx);
        videoActive = va;
        border      = bord;
        coloridx    = cidx;
        border_idx  = bidx;
    endtask

    task automatic checkOutput(input string tag, input logic [11:0] obs,
                               input logic [11:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic writePal(input logic [3:0] addr, input logic [7:0] data);
        alignCe(1'b0);
        pal_wr     = 1'b1;
        border_idx = addr;
        pal_data   = data;
        tick();
        pal_wr = 1'b0;
        tick();
    endtask

    initial begin
        ce12 = 1'b0;
        reset = 1'b1;
        hsync = 1'b0;
        vsync = 1'b0;
        pal_wr = 1'b1;
        pal_data = 8'hAA;
        applyStimulus(1'b1, 1'b0, 4'h9, 4'h5);
        repeat (3) tick();
        checkOutput("reset_rgb", rgbA, 12'h000);
        checkOutput("reset_hs", {11'd0, busA.vga_hs}, 12'h001);
        checkOutput("reset_vs", {11'd0, busA.vga_vs}, 12'h001);
        checkOutput("reset_busy", {11'd0, busA.pal_busy}, 12'h000);

        reset = 1'b0;
        pal_wr = 1'b0;
        hsync = 1'b1;
        vsync = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) coloridx = 4'(i);
            tick();
            if (i >= 1) checkOutput("readback_zero", rgbA, 12'h000);
        end

        $display("[TB] write then display");
        alignCe(1'b0);
        pal_wr = 1'b1;
        border_idx = 4'd5;
        pal_data = 8'b10_011_110;
        tick();
        pal_wr = 1'b0;
        checkOutput("busy_after_capture", {11'd0, busA.pal_busy}, 12'h001);
        tick();
        checkOutput("busy_after_commit", {11'd0, busA.pal_busy}, 12'h000);
        applyStimulus(1'b1, 1'b0, 4'd5, 4'd5);
        tick();
        tick();
        checkOutput("entry5_rgbA", rgbA, 12'hD6A);
        checkOutput("entry5_rgbB", rgbB, 12'hD6A);

        $display("[TB] latency and blanking");
        hsync = 1'b0;
        vsync = 1'b0;
        videoActive = 1'b0;
        tick();
        checkOutput("hs_one_cycle", {11'd0, busA.vga_hs}, 12'h001);
        tick();
        checkOutput("hs_two_cycles", {11'd0, busA.vga_hs}, 12'h000);
        checkOutput("vs_two_cycles", {11'd0, busA.vga_vs}, 12'h000);
        checkOutput("blank_rgb", rgbA, 12'h000);
        hsync = 1'b1;
        vsync = 1'b1;
        videoActive = 1'b1;
        tick();
        checkOutput("hs_hold", {11'd0, busA.vga_hs}, 12'h000);
        checkOutput("blank_hold", rgbA, 12'h000);
        tick();
        checkOutput("hs_release", {11'd0, busA.vga_hs}, 12'h001);
        checkOutput("unblank_rgb", rgbA, 12'hD6A);

        $display("[TB] border");
        writePal(4'd3, 8'hFF);
        applyStimulus(1'b1, 1'b1, 4'd0, 4'd3);
        tick();
        tick();
        checkOutput("border_shown", rgbA, 12'hFFF);
        checkOutput("border_blanked", rgbB, 12'h000);

        $display("[TB] mode512 rate");
        writePal(4'd1, 8'h07);
        writePal(4'd2, 8'h38);
        applyStimulus(1'b1, 1'b0, 4'd1, 4'd0);
        for (int i = 0; i < 9; i++) begin
            coloridx = (i % 2 == 0) ? 4'd1 : 4'd2;
            tick();
            if (i >= 1) checkOutput("mode512", rgbA, ((i - 1) % 2 == 0) ? 12'hF00 : 12'h0F0);
        end

        $display("[TB] overwrite while pending");
        alignCe(1'b1);
        pal_wr = 1'b1;
        border_idx = 4'd4;
        pal_data = 8'h01;
        tick();
        checkOutput("ow_busy1", {11'd0, busA.pal_busy}, 12'h001);
        pal_data = 8'h02;
        tick();
        pal_wr = 1'b0;
        checkOutput("ow_busy2", {11'd0, busA.pal_busy}, 12'h001);
        tick();
        checkOutput("ow_busy_clear", {11'd0, busA.pal_busy}, 12'h000);
        applyStimulus(1'b1, 1'b0, 4'd4, 4'd0);
        tick();
        tick();
        checkOutput("ow_last_wins", rgbA, 12'h400);

        $display("[TB] write on commit cycle");
        alignCe(1'b0);
        pal_wr = 1'b1;
        border_idx = 4'd6;
        pal_data = 8'h07;
        tick();
        border_idx = 4'd7;
        pal_data = 8'h38;
        tick();
        pal_wr = 1'b0;
        checkOutput("cc_busy_stays", {11'd0, busA.pal_busy}, 12'h001);
        tick();
        checkOutput("cc_busy_wait", {11'd0, busA.pal_busy}, 12'h001);
        tick();
        checkOutput("cc_busy_clear", {11'd0, busA.pal_busy}, 12'h000);
        applyStimulus(1'b1, 1'b0, 4'd6, 4'd0);
        tick();
        coloridx = 4'd7;
        tick();
        checkOutput("cc_first_entry", rgbA, 12'hF00);
        tick();
        checkOutput("cc_second_entry", rgbA, 12'h0F0);

        $display("[TB] reset during pending write");
        alignCe(1'b0);
        pal_wr = 1'b1;
        border_idx = 4'd8;
        pal_data = 8'hFF;
        tick();
        pal_wr = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rp_busy", {11'd0, busA.pal_busy}, 12'h000);
        applyStimulus(1'b1, 1'b0, 4'd8, 4'd0);
        repeat (3) tick();
        checkOutput("rp_entry_zero", rgbA, 12'h000);
        tick();
        checkOutput("rp_entry_zero_late", rgbA, 12'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/palette_rgb_out.md
Name: palette_rgb_out

Overview:
- Downstream stage of the video scanner. Consumes the scanner's hsync, vsync, videoActive, coloridx and border outputs.
- Maps each 4-bit colour index through a 16-entry CPU-writable palette of 8-bit BBGGGRRR entries. Produces 4-bit-per-channel RGB with syncs delay-matched.
- Palette writes from the CPU port logic are held pending, then committed on a ce12 strobe, so a write never lands between mode512 half-pixels.

Parameters:
- BLANK_BORDER, 0, when 1 the border area is forced to black instead of palette[border_idx].

Ports:
- clk24  input  1  system clock, 24 MHz.
- reset  input  1  synchronous, active-high reset.
- ce12  input  1  12 MHz clock enable, high on alternate clk24 cycles.
- hsync  input  1  active-low horizontal sync from the scanner.
- vsync  input  1  active-low vertical sync from the scanner.
- videoActive  input  1  high inside the visible area, border included.
- border  input  1  high when the current pixel is border.
- coloridx  input  4  pixel colour index; may change every clk24 in mode512.
- border_idx  input  4  border colour index; also the palette write address.
- pal_wr  input  1  one-clk24 write request.
- pal_data  input  8  palette entry to write, BBGGGRRR.
- pal_busy  output  1  high while a write is pending.
- vga_r  output  4  red.
- vga_g  output  4  green.
- vga_b  output  4  blue.
- vga_hs  output  1  active-low hsync, delayed.
- vga_vs  output  1  active-low vsync, delayed.

Behaviour:
- All state is clocked on posedge clk24. There is no asynchronous logic.
- Reset values:
  - All 16 palette entries = 8'h00.
  - Pending register = 0, pal_busy = 0.
  - vga_r, vga_g and vga_b = 0.
  - vga_hs = vga_vs = 1.
  - Pipeline stages are cleared to the blank/inactive state.
  - Reset in mid-write discards the pending write.
- Stage 1 (every clk24, not gated by ce12):
  - Register sel_idx = border ? border_idx : coloridx.
  - Register blank = !videoActive | (border & BLANK_BORDER).
  - Register hs1 and vs1 from the inputs.
- Stage 2 (every clk24): read entry = palette[sel_idx], then expand it:
  - vga_r = {R[2:0], R[2]}, where R = entry[2:0].
  - vga_g = {G[2:0], G[2]}, where G = entry[5:3].
  - vga_b = {B[1:0], B[1:0]}, where B = entry[7:6].
  - If blank, all three channels = 0.
  - vga_hs = hs1 and vga_vs = vs1.
- Latency is exactly 2 clk24 from input to RGB and sync outputs, with colour and syncs aligned.
- Write handshake is a two-state machine:
  - IDLE: on pal_wr, capture addr = border_idx and data = pal_data, then go to PEND with pal_busy = 1.
  - PEND: on the first clk24 with ce12 = 1, write palette[addr] = data and return to IDLE (pal_busy = 0 on the next cycle).
    - The write takes effect in stage 2 starting the cycle after the commit edge.
  - If the capture cycle itself has ce12 = 1, the commit occurs at the next ce12, never in the same cycle.
  - pal_wr while in PEND overwrites addr/data; the last writer wins, and the commit still happens at the next ce12.
  - pal_wr on the exact cycle of a commit: the old pending value is committed, the new value is captured, and the machine stays in PEND.
- A palette read and write to the same entry in the same cycle returns the old value; there is no bypass.
- An X or illegal FSM state recovers to IDLE.

Test Plan:
- Reset behaviour: assert reset for 3 cycles with arbitrary inputs -> RGB = 0, vga_hs = vga_vs = 1, pal_busy = 0; palette readback via pixels with coloridx 0..15 gives all zeros.
- Write then display: pal_wr with border_idx = 5 and pal_data = 8'b10_011_110 on a ce12 = 0 cycle:
  - pal_busy is high for exactly 1 cycle and the commit lands on the next ce12.
  - Afterwards, videoActive = 1, border = 0, coloridx = 5 -> 2 cycles later vga_r = 4'hD, vga_g = 4'h6, vga_b = 4'hA.
- Latency and blanking: toggle hsync and videoActive at a known cycle -> vga_hs follows exactly 2 clk24 later; RGB reads 0 on those cycles with videoActive = 0.
- Border handling: border = 1, border_idx = 3, palette[3] = 8'hFF -> RGB = F/F/F with BLANK_BORDER = 0, and RGB = 0 with BLANK_BORDER = 1.
- Mode512 rate: coloridx alternates 1/2 every clk24, with palette[1] = 8'h07 and palette[2] = 8'h38 -> output alternates vga_r = F and vga_g = F every clk24 with no dropped pixel.
- Write collisions: back-to-back pal_wr to entries 4 then 4 -> final value is the second pal_data.
  - A pal_wr on the commit cycle -> pal_busy stays high and both values commit in order.
  - Reset during PEND -> the entry remains 0.
